// File: rtl/card_dealer.sv
// card_dealer -- shared 52-card shoe for the blackjack game.
//
// Arbitrates draw requests from the player and dealer hand sequencers and
// deals random cards from a free-running Galois LFSR. A used-card mask
// guarantees no card is dealt twice until the next shuffle.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_player, req_dealer  level draw requests, held until the matching ack
//   ack_player, ack_dealer  one-cycle pulse; card_rank/card_suit/deck_empty valid
//   card_rank  [3:0]        1..13 (Ace..King), 0 when deck_empty
//   card_suit  [1:0]        0..3
//   deck_empty              with ack: shoe was exhausted, no card dealt
//   cards_left [5:0]        undealt cards, 0..52
//   shuffle                 pulse: return all cards to the shoe
//   seed_load, seed_value   pulse: reload the LFSR (0 is mapped to 1)
//   busy                    a draw is in flight (SEARCH or DELIVER)
module card_dealer #(
    parameter logic [15:0] LFSR_TAPS  = 16'hB400,
    parameter logic [15:0] RESET_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_player,
    input  logic        req_dealer,
    output logic        ack_player,
    output logic        ack_dealer,
    output logic [3:0]  card_rank,
    output logic [1:0]  card_suit,
    output logic        deck_empty,
    output logic [5:0]  cards_left,
    input  logic        shuffle,
    input  logic        seed_load,
    input  logic [15:0] seed_value,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DELIVER = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [15:0] lfsr, lfsr_adv;
    logic [51:0] used;
    logic [63:0] used_ext;
    logic [5:0]  cand;
    logic        cand_hit;
    logic [1:0]  cand_suit;
    logic [3:0]  cand_rank;
    logic [5:0]  rank_tmp;
    logic        shuffle_pending;
    logic        last_grant_dealer;  // 1 = dealer won the last grant
    logic        grant_dealer;       // owner of the draw in flight
    logic        gnt_dealer_nxt;
    logic        any_req, do_shuffle;

    assign lfsr_adv = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    assign cand     = lfsr[5:0];
    // Pad the mask to the full 6-bit candidate range so out-of-deck
    // candidates (52..63) index safely; they are rejected by the compare.
    assign used_ext = {12'd0, used};
    assign cand_hit = (cand < 6'd52) && !used_ext[cand];

    assign any_req    = req_player | req_dealer;
    assign do_shuffle = shuffle_pending | shuffle;
    // On a tie the requester that did not win last time gets the card.
    assign gnt_dealer_nxt = req_dealer & (~req_player | ~last_grant_dealer);

    // Index -> (suit, rank) by compare/subtract against the suit boundaries.
    always_comb begin
        cand_suit = 2'd0;
        rank_tmp  = cand + 6'd1;
        if (cand < 6'd13) begin
            cand_suit = 2'd0;
            rank_tmp  = cand + 6'd1;
        end else if (cand < 6'd26) begin
            cand_suit = 2'd1;
            rank_tmp  = cand - 6'd12;
        end else if (cand < 6'd39) begin
            cand_suit = 2'd2;
            rank_tmp  = cand - 6'd25;
        end else begin
            cand_suit = 2'd3;
            rank_tmp  = cand - 6'd38;
        end
        cand_rank = rank_tmp[3:0];
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!do_shuffle && any_req)
                    state_nxt = (cards_left == 6'd0) ? DELIVER : SEARCH;
            end
            SEARCH:  if (cand_hit) state_nxt = DELIVER;
            DELIVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ack_player = (state == DELIVER) && !grant_dealer;
        ack_dealer = (state == DELIVER) &&  grant_dealer;
        busy       = (state != IDLE);
    end

    // LFSR runs in every state; a seed load replaces that cycle's advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         lfsr <= RESET_SEED;
        else if (seed_load) lfsr <= (seed_value == 16'h0000) ? 16'h0001 : seed_value;
        else                lfsr <= lfsr_adv;
    end

    // Deck, grant and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used              <= '0;
            cards_left        <= 6'd52;
            shuffle_pending   <= 1'b0;
            last_grant_dealer <= 1'b1;
            grant_dealer      <= 1'b0;
            card_rank         <= 4'd0;
            card_suit         <= 2'd0;
            deck_empty        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_shuffle) begin
                        used            <= '0;
                        cards_left      <= 6'd52;
                        shuffle_pending <= 1'b0;
                    end else if (any_req) begin
                        grant_dealer      <= gnt_dealer_nxt;
                        last_grant_dealer <= gnt_dealer_nxt;
                        if (cards_left == 6'd0) begin
                            deck_empty <= 1'b1;
                            card_rank  <= 4'd0;
                            card_suit  <= 2'd0;
                        end
                    end
                end
                SEARCH: begin
                    if (cand_hit) begin
                        used[cand]  <= 1'b1;
                        cards_left  <= cards_left - 6'd1;
                        card_rank   <= cand_rank;
                        card_suit   <= cand_suit;
                        deck_empty  <= 1'b0;
                    end
                end
                default: ;
            endcase
            // A shuffle during a draw waits; the draw finishes on the old mask.
            if (state != IDLE && shuffle) shuffle_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer. A per-cycle LFSR trace plus a
// transaction-level deck model predicts which card each draw yields, when
// the ack fires, and who gets it.
module tb_card_dealer;

    localparam logic [15:0] TAPS  = 16'hB400;
    localparam logic [15:0] SEED0 = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_player = 1'b0, req_dealer = 1'b0;
    logic        ack_player, ack_dealer;
    logic [3:0]  card_rank;
    logic [1:0]  card_suit;
    logic        deck_empty;
    logic [5:0]  cards_left;
    logic        shuffle = 1'b0, seed_load = 1'b0;
    logic [15:0] seed_value = 16'h0;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    card_dealer dut (
        .clk(clk), .rst_n(rst_n),
        .req_player(req_player), .req_dealer(req_dealer),
        .ack_player(ack_player), .ack_dealer(ack_dealer),
        .card_rank(card_rank), .card_suit(card_suit),
        .deck_empty(deck_empty), .cards_left(cards_left),
        .shuffle(shuffle), .seed_load(seed_load), .seed_value(seed_value),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // ---- reference model ----
    int          cyc = 0;
    logic [15:0] m_lfsr;
    logic [15:0] hist [0:8191];   // LFSR value during each cycle
    bit          used [52];
    bit          dut_seen [52];
    int          m_left;
    bit          m_last;          // 1 = dealer won last grant

    function automatic logic [15:0] lfsr_next(input logic [15:0] v, input logic sl,
                                              input logic [15:0] sv);
        if (sl) return (sv == 16'h0) ? 16'h0001 : sv;
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr          <= SEED0;
            hist[cyc & 8191] <= SEED0;
        end else begin
            m_lfsr               <= lfsr_next(m_lfsr, seed_load, seed_value);
            hist[(cyc + 1) & 8191] <= lfsr_next(m_lfsr, seed_load, seed_value);
            cyc                  <= cyc + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 52; i++) begin used[i] = 0; dut_seen[i] = 0; end
        m_left = 52;
        m_last = 1;
    endtask

    // Call at the negedge of an IDLE cycle with requests already driven.
    // Follows the draw to its ack, checks it, and drops the granted req.
    task automatic serve(input bit seed_mid, input bit shuf_mid);
        bit   expd, found, early, done, was_empty;
        int   g, ack_c, idx, k, c, didx;
        expd      = req_dealer && (!req_player || !m_last);
        m_last    = expd;
        g         = cyc;
        found     = 0; early = 0; done = 0; idx = 0; ack_c = 0;
        was_empty = (m_left == 0);
        if (was_empty) begin found = 1; ack_c = g + 1; end
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            k = cyc;
            seed_load = 1'b0;
            shuffle   = 1'b0;
            if (k == g + 1) begin
                if (seed_mid) begin seed_value = 16'($urandom); seed_load = 1'b1; end
                if (shuf_mid) shuffle = 1'b1;
            end
            if (found && k == ack_c) begin
                done = 1;
                chk("ack_player", ack_player, !expd);
                chk("ack_dealer", ack_dealer, expd);
                chk("busy_dlv", busy, 1);
                if (was_empty) begin
                    chk("empty_flag", deck_empty, 1);
                    chk("empty_rank", card_rank, 0);
                    chk("empty_suit", card_suit, 0);
                    chk("empty_left", cards_left, 0);
                end else begin
                    used[idx] = 1;
                    m_left--;
                    chk("rank", card_rank, idx % 13 + 1);
                    chk("suit", card_suit, idx / 13);
                    chk("deck_empty", deck_empty, 0);
                    chk("cards_left", cards_left, m_left);
                    if (card_rank >= 1 && card_rank <= 13) begin
                        didx = int'(card_suit) * 13 + int'(card_rank) - 1;
                        chk("dup_card", dut_seen[didx], 0);
                        dut_seen[didx] = 1;
                    end
                end
                chk("early_ack", early, 0);
            end else begin
                if (ack_player || ack_dealer) early = 1;
                if (!found && k >= g + 1) begin
                    c = int'(hist[k & 8191][5:0]);
                    if (c < 52 && !used[c]) begin found = 1; idx = c; ack_c = k + 1; end
                end
            end
        end
        seed_load = 1'b0;
        shuffle   = 1'b0;
        if (!done) chk("ack_timeout", 1, 0);
        if (expd) req_dealer = 1'b0; else req_player = 1'b0;
        if (shuf_mid && done) begin
            @(negedge clk);                 // first IDLE cycle: shuffle applies now
            chk("left_pre_shuf", cards_left, m_left);
            @(negedge clk);
            chk("left_post_shuf", cards_left, 52);
            for (int i = 0; i < 52; i++) begin used[i] = 0; dut_seen[i] = 0; end
            m_left = 52;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int cnt;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ack_p", ack_player, 0);
        chk("rst_ack_d", ack_dealer, 0);
        chk("rst_rank", card_rank, 0);
        chk("rst_suit", card_suit, 0);
        chk("rst_empty", deck_empty, 0);
        chk("rst_left", cards_left, 52);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        // single player draw
        @(negedge clk); req_player = 1'b1; serve(0, 0);
        @(negedge clk); chk("idle_busy", busy, 0);

        // seed 0 loaded together with a request: search starts from 0x0001
        @(negedge clk);
        seed_value = 16'h0000; seed_load = 1'b1; req_player = 1'b1;
        serve(0, 0);

        // both from reset: P, D, then both again: P, D
        rst_n = 1'b0; model_reset();
        req_player = 1'b1; req_dealer = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        serve(0, 0);                        // player
        @(negedge clk); serve(0, 0);        // dealer (still high)
        @(negedge clk); req_player = 1'b1; req_dealer = 1'b1; serve(0, 0);
        @(negedge clk); serve(0, 0);
        chk("left_48", cards_left, 48);

        // exhaust the shoe with random requesters and random mid-search seeds
        while (m_left > 0) begin
            @(negedge clk);
            if ($urandom_range(0, 1) == 1) req_dealer = 1'b1; else req_player = 1'b1;
            serve($urandom_range(0, 3) == 0, 0);
        end
        cnt = 0;
        for (int i = 0; i < 52; i++) cnt += int'(dut_seen[i]);
        chk("unique_52", cnt, 52);
        chk("left_0", cards_left, 0);

        // 53rd draw on an empty shoe
        @(negedge clk); req_player = 1'b1; serve(0, 0);

        // shuffle in IDLE, then a valid draw
        @(negedge clk); shuffle = 1'b1;
        @(negedge clk); shuffle = 1'b0;
        chk("shuf_left", cards_left, 52);
        for (int i = 0; i < 52; i++) begin used[i] = 0; dut_seen[i] = 0; end
        m_left = 52;
        @(negedge clk); req_dealer = 1'b1; serve(0, 0);
        repeat (3) begin
            @(negedge clk); req_player = 1'b1; serve(0, 0);
        end

        // shuffle during SEARCH: draw completes on the old mask, then refill
        @(negedge clk); req_player = 1'b1; serve(0, 1);

        // async reset in the middle of a search
        @(negedge clk); req_player = 1'b1;
        @(negedge clk);                     // DUT now in SEARCH
        rst_n = 1'b0; req_player = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_left", cards_left, 52);
        chk("mid_rst_ack", ack_player, 0);
        model_reset();
        @(negedge clk);
        chk("mid_rst_noack", ack_player | ack_dealer, 0);
        rst_n = 1'b1;
        @(negedge clk); req_dealer = 1'b1; serve(0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Shared card-deck resource for the blackjack game.
- Arbitrates draw requests from the player-hand and dealer-hand sequencers and holds a 52-card used-card mask, so no card is dealt twice per shoe.
- Draws random cards from a free-running 16-bit LFSR.
- Sits between the game FSM and the hand/score logic; the game FSM issues shuffle and seed commands.

Parameters:
- LFSR_TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1).
- RESET_SEED, 16'hACE1, LFSR value after reset; must be non-zero.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_player  input  1  player draw request, level, held until ack_player
- req_dealer  input  1  dealer draw request, level, held until ack_dealer
- ack_player  output  1  one-cycle pulse: card_rank/card_suit/deck_empty valid for player
- ack_dealer  output  1  one-cycle pulse: same, for dealer
- card_rank  output  4  1..13 (1=Ace, 11..13=J/Q/K); 0 when deck_empty
- card_suit  output  2  0..3
- deck_empty  output  1  valid with ack: no card was available
- cards_left  output  6  undealt cards, 0..52
- shuffle  input  1  one-cycle pulse: return all cards to the deck
- seed_load  input  1  one-cycle pulse: load seed_value into the LFSR
- seed_value  input  16  LFSR seed
- busy  output  1  high in SEARCH or DELIVER

Behaviour:
- Reset (async, rst_n=0) values:
  - ack_player=ack_dealer=0, card_rank=0, card_suit=0, deck_empty=0.
  - cards_left=52, used mask all 0, busy=0, LFSR=RESET_SEED.
  - state=IDLE, last_grant=dealer (player wins the first tie), shuffle_pending=0.
- LFSR:
  - Advances every cycle in every state.
  - seed_load overrides the advance that cycle; seed_value 0 loads 16'h0001.
  - Candidate index = lfsr[5:0].
- States: IDLE, SEARCH, DELIVER.
- IDLE:
  - If shuffle_pending or shuffle: clear mask, cards_left=52, clear shuffle_pending; no grant this cycle.
  - Else, if any req: grant one requester.
    - Both requesting: grant the one opposite last_grant; update last_grant.
    - cards_left==0: go to DELIVER with deck_empty=1, rank=0, suit=0.
    - Otherwise: go to SEARCH.
- SEARCH:
  - Each cycle test the candidate.
  - Accept if candidate<52 and mask[candidate]==0: set the mask bit, decrement cards_left, latch suit=candidate/13 and rank=candidate%13+1, go to DELIVER.
  - Otherwise stay. The maximal-length LFSR guarantees termination.
  - No per-draw timeout.
- DELIVER:
  - Assert the granted ack for exactly one cycle; rank/suit/deck_empty are valid that cycle and held until the next ack.
  - Return to IDLE.
  - Minimum latency from req to ack is 3 cycles (IDLE grant, SEARCH hit, DELIVER).
- Handshake:
  - A requester deasserts req in the cycle after its ack.
  - req still high in the first IDLE cycle after its ack counts as a new request.
  - A req dropped before its ack after being granted: the card is still dealt and acked; the requester ignores it.
- shuffle outside IDLE:
  - Sets shuffle_pending and is applied on return to IDLE.
  - The in-flight draw completes against the old mask.
- seed_load is legal in any state and does not abort a search.
- Index-to-card conversion is combinational compare/subtract against 13/26/39; no divider.
- Mid-operation reset: returns to IDLE, no ack emitted, mask cleared.

Test Plan:
- Reset, then single req_player held -> ack_player within 3..N cycles, card_rank in 1..13, card_suit in 0..3, cards_left=51, deck_empty=0, ack_dealer never high.
- seed_value=16'h0000 with seed_load, then a draw -> LFSR holds 16'h0001 before advancing; card matches the reference model seeded with 1.
- req_player and req_dealer both high from reset -> player acked first, dealer second; repeat -> grants alternate P,D,P,D; cards_left 52->48.
- 52 consecutive draws -> all 52 (rank,suit) pairs unique, cards_left=0. 53rd req -> ack with deck_empty=1, card_rank=0. Then shuffle -> cards_left=52, next draw valid.
- shuffle pulse during SEARCH -> current ack delivers a card not previously dealt, cards_left drops by 1, then returns to 52 one cycle after reaching IDLE.
- rst_n low during SEARCH -> no ack, cards_left=52, busy=0 immediately (async).
